// File: rtl/sprite_pkg.sv
// Shared types for the sprite plotter: FSM states, object table entry, screen defaults.
// The ERASE state only exists when SPRITE_PLOTTER_ERASE_EN is defined.
package sprite_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOR_W_DEF  = 3;

`ifdef SPRITE_PLOTTER_ERASE_EN
  typedef enum logic [2:0] {IDLE, SNAP, ERASE, DRAW, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, SNAP, DRAW, FIN} state_t;
`endif

  // Field widths bound the X_W/Y_W/COLOR_W parameters of the plotter.
  typedef struct packed {
    logic [X_W_DEF-1:0]     x;
    logic [Y_W_DEF-1:0]     y;
    logic [COLOR_W_DEF-1:0] color;
    logic                   en;
  } obj_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Walks one OBJ_W x OBJ_H rectangle row-major, one pixel per step, and
// produces the screen address (one bit wider than the coordinates) plus a clip flag.
module rect_scanner
  import sprite_pkg::*;
#(
  parameter int OBJ_W    = 4,
  parameter int OBJ_H    = 4,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W:0] px,
  output logic [Y_W:0] py,
  output logic         on_screen,
  output logic         last_pixel
);
  localparam int DX_W = cnt_w(OBJ_W);
  localparam int DY_W = cnt_w(OBJ_H);

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            last_col, last_row;

  assign last_col   = (dx == DX_W'(OBJ_W - 1));
  assign last_row   = (dy == DY_W'(OBJ_H - 1));
  assign last_pixel = last_col && last_row;

  // Extra top bit keeps base+offset from wrapping back onto the screen.
  assign px        = {1'b0, base_x} + (X_W+1)'(dx);
  assign py        = {1'b0, base_y} + (Y_W+1)'(dy);
  assign on_screen = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      if (last_col) begin
        dx <= '0;
        dy <= last_row ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Frame renderer: snapshots a pending object table, then plots each object's
// rectangle one pixel per cycle. Define SPRITE_PLOTTER_ERASE_EN to erase old positions first.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_W    = 4,
  parameter int OBJ_H    = 4,
  parameter int X_W      = X_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int BG_COLOR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       obj_we,
  input  logic [$clog2(NUM_OBJ)-1:0] obj_idx,
  input  logic [X_W-1:0]             obj_x,
  input  logic [Y_W-1:0]             obj_y,
  input  logic [COLOR_W-1:0]         obj_color,
  input  logic                       obj_en,
  output logic [X_W-1:0]             xpos,
  output logic [Y_W-1:0]             ypos,
  output logic [COLOR_W-1:0]         color,
  output logic                       plot,
  output logic                       busy,
  output logic                       done
);
  localparam int IDX_W = $clog2(NUM_OBJ);

`ifdef SPRITE_PLOTTER_ERASE_EN
  localparam state_t FIRST_PASS = ERASE;
`else
  localparam state_t FIRST_PASS = DRAW;
`endif

  state_t             state;
  logic [IDX_W-1:0]   obj_cnt;
  obj_t               pend [NUM_OBJ];
  obj_t               act  [NUM_OBJ];
  obj_t               wr_ent, cur;
  logic               cur_vis, scanning, on_screen, last_pixel;
  logic [COLOR_W-1:0] cur_color;
  logic [X_W:0]       px;
  logic [Y_W:0]       py;

  assign wr_ent = '{x: X_W_DEF'(obj_x), y: Y_W_DEF'(obj_y),
                    color: COLOR_W_DEF'(obj_color), en: obj_en};

`ifdef SPRITE_PLOTTER_ERASE_EN
  obj_t               prev [NUM_OBJ];
  logic [NUM_OBJ-1:0] prev_valid;

  assign scanning = (state == ERASE) || (state == DRAW);

  // Erase walks the last drawn rectangle; never-drawn or disabled ones stay dark.
  always_comb begin
    cur     = act[obj_cnt];
    cur_vis = cur.en;
    if (state == ERASE) begin
      cur     = prev[obj_cnt];
      cur_vis = prev_valid[obj_cnt] && cur.en;
    end
    cur_color = (state == ERASE) ? COLOR_W'(BG_COLOR) : cur.color[COLOR_W-1:0];
  end
`else
  assign scanning = (state == DRAW);

  always_comb begin
    cur       = act[obj_cnt];
    cur_vis   = cur.en;
    cur_color = cur.color[COLOR_W-1:0];
  end
`endif

  rect_scanner #(
    .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .X_W(X_W), .Y_W(Y_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .step      (scanning),
    .base_x    (cur.x[X_W-1:0]),
    .base_y    (cur.y[Y_W-1:0]),
    .px        (px),
    .py        (py),
    .on_screen (on_screen),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      obj_cnt <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      xpos    <= '0;
      ypos    <= '0;
      color   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
`ifdef SPRITE_PLOTTER_ERASE_EN
        prev[i] <= '0;
`endif
      end
`ifdef SPRITE_PLOTTER_ERASE_EN
      prev_valid <= '0;
`endif
    end else begin
      done <= 1'b0;
      plot <= scanning && on_screen && cur_vis;
      if (scanning) begin
        xpos  <= px[X_W-1:0];
        ypos  <= py[Y_W-1:0];
        color <= cur_color;
      end
      if (obj_we) pend[obj_idx] <= wr_ent;

      case (state)
        IDLE: if (start) begin
          state <= SNAP;
          busy  <= 1'b1;
        end
        SNAP: begin
          // A write landing in this cycle bypasses into the snapshot.
          for (int i = 0; i < NUM_OBJ; i++)
            act[i] <= (obj_we && obj_idx == IDX_W'(i)) ? wr_ent : pend[i];
          obj_cnt <= '0;
          state   <= FIRST_PASS;
        end
`ifdef SPRITE_PLOTTER_ERASE_EN
        ERASE: if (last_pixel) state <= DRAW;
`endif
        DRAW: if (last_pixel) begin
`ifdef SPRITE_PLOTTER_ERASE_EN
          prev[obj_cnt]       <= act[obj_cnt];
          prev_valid[obj_cnt] <= 1'b1;
`endif
          if (obj_cnt == IDX_W'(NUM_OBJ - 1)) begin
            state <= FIN;
          end else begin
            obj_cnt <= obj_cnt + 1'b1;
            state   <= FIRST_PASS;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
